move_controller: RTL and testbench

MOVE_CONTROLLER -- requirements
Module: move_controller

---
 rtl/flood_pkg.sv | 19 +
 rtl/color_cursor.sv | 28 ++
 rtl/move_controller.sv | 133 +++++++++++++
 tb/tb_move_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/flood_pkg.sv
// Shared definitions for the flood-fill game: color and move-count widths,
// the default palette size and the move controller state encoding.
package flood_pkg;

  localparam int COLOR_W            = 3;
  localparam int NUM_COLORS_DEFAULT = 6;
  localparam int COUNT_W            = 6;

  typedef enum logic [2:0] {
    IDLE,
    START_REQ,
    START_REL,
    READY,
    SEL_REQ,
    SEL_WAIT,
    OVER
  } state_t;

endpackage

// File: rtl/color_cursor.sv
// Highlighted-color register with increment/decrement that wraps inside
// the 0..NUM_COLORS-1 palette. Simultaneous inc and dec leave it unchanged.
module color_cursor
  import flood_pkg::*;
#(
  parameter int NUM_COLORS = NUM_COLORS_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [COLOR_W-1:0] color
);

  localparam logic [COLOR_W-1:0] MAX_COLOR = COLOR_W'(NUM_COLORS - 1);

  // Step the cursor one position, wrapping at either end of the palette.
  always_ff @(posedge clock) begin
    if (reset) begin
      color <= '0;
    end else if (inc && !dec) begin
      color <= (color >= MAX_COLOR) ? '0 : color + COLOR_W'(1);
    end else if (dec && !inc) begin
      color <= (color == '0 || color > MAX_COLOR) ? MAX_COLOR : color - COLOR_W'(1);
    end
  end

endmodule

// File: rtl/move_controller.sv
// Move controller for the flood-fill game: owns the game-start handshake with
// the board logic, the color cursor, the color-select handshake, the move
// counter and the move-limit game-over condition.
module move_controller
  import flood_pkg::*;
#(
  parameter int NUM_COLORS = NUM_COLORS_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_select,
  input  logic               btn_new,
  input  logic [COUNT_W-1:0] move_limit,
  input  logic               changing_color,
  input  logic               ack_begin_game,
  output logic [COLOR_W-1:0] color_selected,
  output logic               color_sel_sig,
  output logic               begin_game,
  output logic [COLOR_W-1:0] cursor_color,
  output logic [COUNT_W-1:0] move_count,
  output logic               game_over,
  output logic               busy
);

  state_t             state;
  state_t             next_state;
  logic [COLOR_W-1:0] last_color;
  logic               last_valid;
  logic               new_pending;
  logic               select_ok;
  logic               move_ok;
  logic               sel_done;
  logic               in_select;
  logic               limit_hit;
  logic [COUNT_W-1:0] count_next;

  // A select repeating the color just played would be a no-op flood, so it
  // is dropped. BTN_NEW wins over select, and an accepted select swallows
  // any coincident cursor pulse.
  assign select_ok  = (state == READY) && !btn_new && btn_select &&
                      !(last_valid && (cursor_color == last_color));
  assign move_ok    = (state == READY) && !btn_new && !select_ok;
  assign in_select  = (state == SEL_REQ) || (state == SEL_WAIT);
  assign sel_done   = (state == SEL_WAIT) && !changing_color;
  assign count_next = (move_count == '1) ? move_count : move_count + COUNT_W'(1);
  assign limit_hit  = (move_limit != '0) && (count_next >= move_limit);

  color_cursor #(
    .NUM_COLORS(NUM_COLORS)
  ) u_cursor (
    .clock(clock),
    .reset(reset),
    .inc  (move_ok && btn_right),
    .dec  (move_ok && btn_left),
    .color(cursor_color)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; a BTN_NEW seen during the select handshake is honoured
  // only once the board has finished the flood.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (btn_new) next_state = START_REQ;
      START_REQ: if (ack_begin_game) next_state = START_REL;
      START_REL: if (!ack_begin_game) next_state = READY;
      READY: begin
        if (btn_new) next_state = START_REQ;
        else if (select_ok) next_state = SEL_REQ;
      end
      SEL_REQ:   if (changing_color) next_state = SEL_WAIT;
      SEL_WAIT: begin
        if (!changing_color) begin
          if (new_pending || btn_new) next_state = START_REQ;
          else if (limit_hit) next_state = OVER;
          else next_state = READY;
        end
      end
      OVER:      if (btn_new) next_state = START_REQ;
      default:   next_state = IDLE;
    endcase
  end

  // Request lines and status flags follow the registered state directly, so
  // a reset drops both requests on the very next edge.
  always_comb begin
    begin_game    = (state == START_REQ);
    color_sel_sig = (state == SEL_REQ);
    game_over     = (state == OVER);
    busy          = !((state == READY) || (state == IDLE) || (state == OVER));
  end

  // Move bookkeeping: captured color, committed-move count, last played color
  // and the deferred new-game request.
  always_ff @(posedge clock) begin
    if (reset) begin
      color_selected <= '0;
      move_count     <= '0;
      last_color     <= '0;
      last_valid     <= 1'b0;
      new_pending    <= 1'b0;
    end else begin
      if (select_ok) begin
        color_selected <= cursor_color;
      end
      if ((state == START_REQ) && ack_begin_game) begin
        move_count <= '0;
        last_valid <= 1'b0;
      end
      if (sel_done) begin
        move_count <= count_next;
        last_color <= color_selected;
        last_valid <= 1'b1;
      end
      if (sel_done) begin
        new_pending <= 1'b0;
      end else if (in_select && btn_new) begin
        new_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed testbench for move_controller with NUM_COLORS = 6.
module tb_move_controller;

  logic       clock;
  logic       reset;
  logic       btn_left;
  logic       btn_right;
  logic       btn_select;
  logic       btn_new;
  logic [5:0] move_limit;
  logic       changing_color;
  logic       ack_begin_game;
  logic [2:0] color_selected;
  logic       color_sel_sig;
  logic       begin_game;
  logic [2:0] cursor_color;
  logic [5:0] move_count;
  logic       game_over;
  logic       busy;

  int checks = 0;
  int passes = 0;

  move_controller #(
    .NUM_COLORS(6)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_select    (btn_select),
    .btn_new       (btn_new),
    .move_limit    (move_limit),
    .changing_color(changing_color),
    .ack_begin_game(ack_begin_game),
    .color_selected(color_selected),
    .color_sel_sig (color_sel_sig),
    .begin_game    (begin_game),
    .cursor_color  (cursor_color),
    .move_count    (move_count),
    .game_over     (game_over),
    .busy          (busy)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_game();
    btn_new = 1'b1; tick(); btn_new = 1'b0;
    ack_begin_game = 1'b1; tick();
    ack_begin_game = 1'b0; tick();
  endtask

  task automatic handshake();
    btn_select = 1'b1; tick(); btn_select = 1'b0;
    changing_color = 1'b1; tick();
    tick();
    changing_color = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_new = 1'b1; tick(); reset = 1'b0; btn_new = 1'b0;
    checks++; if (begin_game !== 1'b0) $display("[TB] FAIL reset_begin: got %0b expected 0", begin_game); else passes++;
    checks++; if (color_sel_sig !== 1'b0) $display("[TB] FAIL reset_sel_sig: got %0b expected 0", color_sel_sig); else passes++;
    checks++; if (cursor_color !== 3'd0) $display("[TB] FAIL reset_cursor: got %0d expected 0", cursor_color); else passes++;
    checks++; if (color_selected !== 3'd0) $display("[TB] FAIL reset_selected: got %0d expected 0", color_selected); else passes++;
    checks++; if (move_count !== 6'd0) $display("[TB] FAIL reset_count: got %0d expected 0", move_count); else passes++;
    checks++; if ({game_over, busy} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {game_over, busy}); else passes++;
  endtask

  task automatic test_start();
    btn_new = 1'b1; tick(); btn_new = 1'b0;
    checks++; if (begin_game !== 1'b1) $display("[TB] FAIL start_begin_rise: got %0b expected 1", begin_game); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL start_busy: got %0b expected 1", busy); else passes++;
    tick(); tick(); tick();
    checks++; if (begin_game !== 1'b1) $display("[TB] FAIL start_begin_held: got %0b expected 1", begin_game); else passes++;
    ack_begin_game = 1'b1; tick();
    checks++; if (begin_game !== 1'b0) $display("[TB] FAIL start_begin_fall: got %0b expected 0", begin_game); else passes++;
    tick();
    checks++; if (busy !== 1'b1) $display("[TB] FAIL start_rel_busy: got %0b expected 1", busy); else passes++;
    ack_begin_game = 1'b0; tick();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL start_ready: got busy %0b expected 0", busy); else passes++;
    checks++; if (move_count !== 6'd0) $display("[TB] FAIL start_count: got %0d expected 0", move_count); else passes++;
  endtask

  task automatic test_wrap();
    btn_left = 1'b1; tick(); btn_left = 1'b0;
    checks++; if (cursor_color !== 3'd5) $display("[TB] FAIL wrap_left: got %0d expected 5", cursor_color); else passes++;
    btn_right = 1'b1; tick(); btn_right = 1'b0;
    checks++; if (cursor_color !== 3'd0) $display("[TB] FAIL wrap_right: got %0d expected 0", cursor_color); else passes++;
    btn_left = 1'b1; btn_right = 1'b1; tick(); btn_left = 1'b0; btn_right = 1'b0;
    checks++; if (cursor_color !== 3'd0) $display("[TB] FAIL wrap_both: got %0d expected 0", cursor_color); else passes++;
    btn_right = 1'b1; tick(); tick(); btn_right = 1'b0;
    btn_left = 1'b1; btn_right = 1'b1; tick(); btn_left = 1'b0; btn_right = 1'b0;
    checks++; if (cursor_color !== 3'd2) $display("[TB] FAIL wrap_both_mid: got %0d expected 2", cursor_color); else passes++;
    btn_left = 1'b1; tick(); tick(); btn_left = 1'b0;
  endtask

  task automatic test_select();
    int sig_cycles = 0;
    logic stable = 1'b1;
    btn_right = 1'b1; tick(); tick(); tick(); btn_right = 1'b0;
    checks++; if (cursor_color !== 3'd3) $display("[TB] FAIL sel_cursor: got %0d expected 3", cursor_color); else passes++;
    btn_select = 1'b1; tick(); btn_select = 1'b0;
    checks++; if (color_sel_sig !== 1'b1) $display("[TB] FAIL sel_latency: got %0b expected 1", color_sel_sig); else passes++;
    sig_cycles += int'(color_sel_sig);
    tick(); sig_cycles += int'(color_sel_sig);
    tick(); sig_cycles += int'(color_sel_sig);
    changing_color = 1'b1; tick(); sig_cycles += int'(color_sel_sig);
    for (int i = 0; i < 9; i++) begin
      if (color_selected !== 3'd3 || color_sel_sig !== 1'b0) stable = 1'b0;
      tick();
    end
    checks++; if (sig_cycles !== 3) $display("[TB] FAIL sel_sig_cycles: got %0d expected 3", sig_cycles); else passes++;
    checks++; if (stable !== 1'b1) $display("[TB] FAIL sel_hold_stable: got %0b expected 1", stable); else passes++;
    checks++; if (color_selected !== 3'd3) $display("[TB] FAIL sel_color: got %0d expected 3", color_selected); else passes++;
    changing_color = 1'b0; tick();
    checks++; if (move_count !== 6'd1) $display("[TB] FAIL sel_count: got %0d expected 1", move_count); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL sel_ready: got busy %0b expected 0", busy); else passes++;
    btn_select = 1'b1; tick(); btn_select = 1'b0;
    checks++; if ({color_sel_sig, busy} !== 2'b00) $display("[TB] FAIL sel_repeat_ignored: got %b expected 00", {color_sel_sig, busy}); else passes++;
    tick();
    checks++; if (move_count !== 6'd1) $display("[TB] FAIL sel_repeat_count: got %0d expected 1", move_count); else passes++;
  endtask

  task automatic test_limit();
    reset = 1'b1; tick(); reset = 1'b0;
    move_limit = 6'd2;
    start_game();
    handshake();
    checks++; if ({move_count, game_over} !== {6'd1, 1'b0}) $display("[TB] FAIL limit_first: got count %0d over %0b expected 1 0", move_count, game_over); else passes++;
    btn_right = 1'b1; tick(); btn_right = 1'b0;
    handshake();
    checks++; if (game_over !== 1'b1) $display("[TB] FAIL limit_over: got %0b expected 1", game_over); else passes++;
    checks++; if ({move_count, busy} !== {6'd2, 1'b0}) $display("[TB] FAIL limit_count: got count %0d busy %0b expected 2 0", move_count, busy); else passes++;
    btn_select = 1'b1; btn_left = 1'b1; tick(); btn_select = 1'b0; btn_left = 1'b0;
    tick();
    checks++; if (color_sel_sig !== 1'b0) $display("[TB] FAIL limit_no_select: got %0b expected 0", color_sel_sig); else passes++;
    checks++; if (cursor_color !== 3'd1) $display("[TB] FAIL limit_no_move: got %0d expected 1", cursor_color); else passes++;
    btn_new = 1'b1; tick(); btn_new = 1'b0;
    checks++; if ({begin_game, game_over} !== 2'b10) $display("[TB] FAIL limit_restart: got %b expected 10", {begin_game, game_over}); else passes++;
    ack_begin_game = 1'b1; tick(); ack_begin_game = 1'b0; tick();
    checks++; if (move_count !== 6'd0) $display("[TB] FAIL limit_restart_count: got %0d expected 0", move_count); else passes++;
  endtask

  task automatic test_new_pending();
    move_limit = 6'd0;
    btn_select = 1'b1; tick(); btn_select = 1'b0;
    changing_color = 1'b1; btn_new = 1'b1; tick(); btn_new = 1'b0;
    tick();
    checks++; if ({busy, begin_game} !== 2'b10) $display("[TB] FAIL pend_wait: got %b expected 10", {busy, begin_game}); else passes++;
    changing_color = 1'b0; tick();
    checks++; if (begin_game !== 1'b1) $display("[TB] FAIL pend_restart: got %0b expected 1", begin_game); else passes++;
    checks++; if (move_count !== 6'd1) $display("[TB] FAIL pend_count: got %0d expected 1", move_count); else passes++;
    ack_begin_game = 1'b1; tick();
    checks++; if (move_count !== 6'd0) $display("[TB] FAIL pend_clear: got %0d expected 0", move_count); else passes++;
    ack_begin_game = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    btn_select = 1'b1; btn_right = 1'b1; tick(); btn_select = 1'b0; btn_right = 1'b0;
    checks++; if ({color_sel_sig, color_selected, cursor_color} !== {1'b1, 3'd1, 3'd1}) $display("[TB] FAIL coinc_select: got sig %0b sel %0d cur %0d expected 1 1 1", color_sel_sig, color_selected, cursor_color); else passes++;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if ({color_sel_sig, busy} !== 2'b00) $display("[TB] FAIL rst_mid_sel: got %b expected 00", {color_sel_sig, busy}); else passes++;
    checks++; if ({color_selected, cursor_color} !== 6'd0) $display("[TB] FAIL rst_mid_colors: got %0d %0d expected 0 0", color_selected, cursor_color); else passes++;
    btn_right = 1'b1; tick(); btn_right = 1'b0;
    btn_select = 1'b1; tick(); btn_select = 1'b0;
    checks++; if ({cursor_color, color_sel_sig} !== 4'd0) $display("[TB] FAIL idle_ignore: got cur %0d sig %0b expected 0 0", cursor_color, color_sel_sig); else passes++;
    btn_new = 1'b1; tick(); btn_new = 1'b0;
    ack_begin_game = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (begin_game !== 1'b0) $display("[TB] FAIL rst_mid_start: got %0b expected 0", begin_game); else passes++;
    tick();
    checks++; if ({begin_game, busy} !== 2'b00) $display("[TB] FAIL rst_stays_idle: got %b expected 00", {begin_game, busy}); else passes++;
    ack_begin_game = 1'b0;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_select = 1'b0; btn_new = 1'b0;
    move_limit = 6'd0; changing_color = 1'b0; ack_begin_game = 1'b0;
    test_reset();
    test_start();
    test_wrap();
    test_select();
    test_limit();
    test_new_pending();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
